circuit: RTL and testbench

// - Serial sequence detector: Moore FSM sampling 1-bit input w on each rising clk edge.
// - Asserts z while the four most recently sampled bits are 1,1,0,1 (oldest first); overlaps allowed.
// - Leaf block; z is a registered-state decode intended as a single-cycle detect flag for downstream logic.

---
 rtl/circuit.sv | 49 ++++
 tb/tb_circuit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/circuit.sv
// Moore detector for the serial pattern 1101 (oldest bit first), overlaps allowed.
// z is decoded purely from the registered state, so there is no path from w to z.
module circuit (
  input  logic clk,
  input  logic rst,
  input  logic w,
  output logic z
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  state_t state_q, state_d;

  // Reset is active-low and asynchronous: any partial match is discarded at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state is the longest prefix of 1101 matched so far. Unused encodings return to S0.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0:      state_d = w ? S1 : S0;
      S1:      state_d = w ? S2 : S0;
      S2:      state_d = w ? S2 : S3;
      S3:      state_d = w ? S4 : S0;
      S4:      state_d = w ? S2 : S0;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    z = 1'b0;
    if (state_q == S4) begin
      z = 1'b1;
    end
  end

endmodule

// File: tb/tb_circuit.sv
// Directed bench for the 1101 detector: each scenario drives w on the falling edge
// and checks z shortly after the following rising edge.
module tb_circuit;

  logic clk;
  logic rst;
  logic w;
  logic z;

  int checks;
  int failures;

  circuit dut (
    .clk(clk),
    .rst(rst),
    .w(w),
    .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one bit and waits until just after the edge that samples it.
  task automatic send_bit(input logic b);
    @(negedge clk);
    w = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    w   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (z !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_z cycle %0d: got %b expected 0", i, z);
      end
      checks++;
      if (3'(dut.state_q) !== 3'b000) begin
        failures++;
        $display("[TB] FAIL reset_state cycle %0d: got %b expected 000", i, 3'(dut.state_q));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (z !== 1'b0 || 3'(dut.state_q) !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_release: got z=%b state=%b expected z=0 state=000", z, 3'(dut.state_q));
    end
  endtask

  task automatic test_basic();
    logic [4:0] ws;
    logic [4:0] zs;
    ws = 5'b11010;
    zs = 5'b00010;
    for (int i = 4; i >= 0; i--) begin
      send_bit(ws[i]);
      checks++;
      if (z !== zs[i]) begin
        failures++;
        $display("[TB] FAIL basic bit %0d: got %b expected %b", 4 - i, z, zs[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] ws;
    logic [6:0] zs;
    ws = 7'b1101101;
    zs = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      send_bit(ws[i]);
      checks++;
      if (z !== zs[i]) begin
        failures++;
        $display("[TB] FAIL overlap bit %0d: got %b expected %b", 6 - i, z, zs[i]);
      end
    end
    send_bit(1'b0);
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overlap_flush: got %b expected 0", z);
    end
  endtask

  task automatic test_long_ones();
    logic [5:0] ws;
    logic [5:0] zs;
    ws = 6'b111101;
    zs = 6'b000001;
    for (int i = 5; i >= 0; i--) begin
      send_bit(ws[i]);
      checks++;
      if (z !== zs[i]) begin
        failures++;
        $display("[TB] FAIL long_ones bit %0d: got %b expected %b", 5 - i, z, zs[i]);
      end
    end
    send_bit(1'b0);
    send_bit(1'b0);
  endtask

  task automatic test_near_miss();
    logic [7:0] ws;
    ws = 8'b10111001;
    for (int i = 7; i >= 0; i--) begin
      send_bit(ws[i]);
      checks++;
      if (z !== 1'b0) begin
        failures++;
        $display("[TB] FAIL near_miss bit %0d: got %b expected 0", 7 - i, z);
      end
    end
    send_bit(1'b0);
    send_bit(1'b0);
  endtask

  task automatic test_async_reset();
    logic [3:0] ws;
    logic [3:0] zs;
    // Reach S3, then pull reset low between edges.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    checks++;
    if (3'(dut.state_q) !== 3'b011) begin
      failures++;
      $display("[TB] FAIL async_pre_state: got %b expected 011", 3'(dut.state_q));
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (z !== 1'b0 || 3'(dut.state_q) !== 3'b000) begin
      failures++;
      $display("[TB] FAIL async_s3_reset: got z=%b state=%b expected z=0 state=000", z, 3'(dut.state_q));
    end
    @(negedge clk);
    rst = 1'b1;
    ws = 4'b1101;
    zs = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      send_bit(ws[i]);
      checks++;
      if (z !== zs[i]) begin
        failures++;
        $display("[TB] FAIL async_restart bit %0d: got %b expected %b", 3 - i, z, zs[i]);
      end
    end
    // z is high now; an asynchronous reset must drop it without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (z !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_s4_reset: got %b expected 0", z);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    w        = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_long_ones();
    test_near_miss();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
